spi_byte_engine: RTL and testbench
==================================

# spi_byte_engine

Byte-level SPI mode-0 master shift engine that sits directly downstream of `clock_divider`. It:
- accepts a parallel byte on a valid/ready handshake;
- triggers the divider with a one-cycle start strobe;
- shifts the byte out on MOSI, using the divided clock's edges as in-domain strobes;
- captures MISO into a receive byte, reported with a one-cycle valid pulse.

All logic runs on `i_clk`. `o_sclk` is a registered copy of the divider clock, and the engine never generates its own serial clock.

## Interface
- `WIDTH`, 8, bits per frame; must match the 8 SCLK periods the divider emits per start.
- `i_clk`  in  1  system clock; `clock_divider` runs on the same clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_tx_data`  in  WIDTH  byte to transmit.
- `i_tx_valid`  in  1  byte offered.
- `o_tx_ready`  out  1  engine can accept a byte; transfer occurs when valid & ready.
- `o_rx_data`  out  WIDTH  byte received in the last frame; held until the next frame completes.
- `o_rx_valid`  out  1  one-cycle pulse, with `o_rx_data` valid.
- `o_err`  out  1  one-cycle pulse alongside `o_rx_valid` when the divider finished with rise count != WIDTH.
- `i_div_clk`  in  1  `clock_divider` `o_clk`.
- `i_div_ready`  in  1  `clock_divider` `o_ready`.
- `o_div_start_n`  out  1  active-low start strobe to the divider.
- `o_sclk`  out  1  pad SCLK, registered copy of `i_div_clk`.
- `o_mosi`  out  1  serial data out.
- `i_miso`  in  1  serial data in.
- `o_cs_n`  out  1  active-low chip select.

## Operation
States and transitions:
- **IDLE**: `o_tx_ready`=1. On valid & ready, latch `i_tx_data` into shift reg, drive first bit on `o_mosi`, `o_cs_n`=0, go to SETUP.
- **SETUP**: one cycle of CS-to-SCLK setup. Go to START.
- **START**: `o_div_start_n`=0 for exactly this cycle. Go to ARM.
- **ARM**: wait for `i_div_ready`=0, then go to SHIFT. No timeout; the divider is trusted to drop ready.
- **SHIFT**: track edges as `rise = i_div_clk & ~div_clk_q`.
  - On each `rise`: sample `i_miso` into rx shift reg, advance tx shift reg, put next bit on `o_mosi`, increment 4-bit rise counter.
  - After the WIDTH-th rise, `o_mosi` holds the last bit shifted (don't-care).
  - On `i_div_ready`=1 (also when it is 1 in the same cycle as a `rise`): go to DONE.
- **DONE**:
  - Load `o_rx_data` from rx reg, pulse `o_rx_valid`, pulse `o_err` iff rise count != WIDTH.
  - `o_cs_n`=1, clear counter, return to IDLE.
- **Reset**: forces IDLE from any state. The divider is not reset by this block; a mid-frame reset abandons the frame and emits no `o_rx_valid`.
- `i_tx_valid` is ignored outside IDLE; `i_tx_data` is sampled only at the handshake.

## Timing
Reset values (async):
- `o_tx_ready`=1 from the first cycle after reset deasserts; 0 while in reset.
- `o_cs_n`=1, `o_div_start_n`=1, `o_sclk`=0, `o_mosi`=0.
- `o_rx_data`=0, `o_rx_valid`=0, `o_err`=0, `div_clk_q`=0.

Cycle-level behaviour:
- Handshake at cycle T: `o_cs_n` low from T+1, `o_div_start_n` low during T+2 only.
- `o_sclk` lags `i_div_clk` by 1 cycle. Rise detection also lags by 1 cycle, so MISO is sampled one `i_clk` after the pad SCLK rises.
- MOSI changes on the same cycle as the detected rise, giving ≥1 `i_clk` hold after pad SCLK rise. Supports divisor ≥2.
- `o_rx_valid` fires 1 cycle after `i_div_ready` re-asserts.
- `o_tx_ready` returns the cycle after `o_rx_valid`.
- Minimum frame-to-frame gap: 4 cycles (DONE, IDLE handshake, SETUP, START).

## Configuration
- `SPI_BYTE_ENGINE_LSB_FIRST_EN`:
  - Defined: LSB transmitted first; received bits fill from MSB down, so `o_rx_data` bit 0 is the first bit received.
  - Undefined (default): MSB first on both MOSI and MISO.

## Test plan
- Reset held 16 cycles, then released → all outputs at reset values, `o_tx_ready`=1, `o_cs_n`=1.
- Divider configured with divisor 2; send 0xA5 with `i_miso` looped to `o_mosi` → MOSI bit sequence 1,0,1,0,0,1,0,1; `o_rx_data`=0xA5 with a single `o_rx_valid`; `o_err`=0.
- Divisor 4; send 0x3C then 0xC3 back-to-back (valid held) → two frames, `o_cs_n` high exactly 1 cycle between them, rx 0x3C then 0xC3.
- `i_miso` tied 1, send 0x00 → `o_rx_data`=0xFF, MOSI constant 0 during the frame.
- Reset asserted after the 3rd SCLK rise → outputs return to reset values immediately; no `o_rx_valid`; next byte 0x5A transfers cleanly.
- Bench divider model raising ready after 6 rises → `o_rx_valid` and `o_err` pulse together, engine back in IDLE.

Source files
------------

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shift engine driven by an external clock_divider on the same clock.
// Define SPI_BYTE_ENGINE_LSB_FIRST_EN for LSB-first framing; default is MSB first.
module spi_byte_engine #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_err,
    input  logic             i_div_clk,
    input  logic             i_div_ready,
    output logic             o_div_start_n,
    output logic             o_sclk,
    output logic             o_mosi,
    input  logic             i_miso,
    output logic             o_cs_n
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_ARM,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [3:0] WIDTH_CNT = 4'(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] tx_shift_reg, rx_shift_reg, rx_data_reg;
    logic [WIDTH-1:0] tx_shifted, rx_shifted, rx_capture;
    logic [3:0]       rise_cnt_reg;
    logic             div_clk_q, rise_reg, ready_reg, cs_n_reg;
    logic             handshake, rise_evt, frame_end;

    genvar gi;

`ifdef SPI_BYTE_ENGINE_LSB_FIRST_EN
    // tx leaves from bit 0; rx enters at the MSB so the first bit lands in bit 0
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
        assign tx_shifted[gi] = tx_shift_reg[gi+1];
        assign rx_shifted[gi] = rx_shift_reg[gi+1];
    end
    assign tx_shifted[WIDTH-1] = 1'b0;
    assign rx_shifted[WIDTH-1] = i_miso;
    assign o_mosi              = tx_shift_reg[0];
`else
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
        assign tx_shifted[gi+1] = tx_shift_reg[gi];
        assign rx_shifted[gi+1] = rx_shift_reg[gi];
    end
    assign tx_shifted[0] = 1'b0;
    assign rx_shifted[0] = i_miso;
    assign o_mosi        = tx_shift_reg[WIDTH-1];
`endif

    assign handshake  = ready_reg & i_tx_valid;
    assign rise_evt   = rise_reg & (state_reg == ST_SHIFT);
    assign frame_end  = i_div_ready & (state_reg == ST_SHIFT);
    // a rise landing in the same cycle as ready must still reach o_rx_data
    assign rx_capture = rise_evt ? rx_shifted : rx_shift_reg;

    assign o_tx_ready = ready_reg;
    assign o_rx_data  = rx_data_reg;
    assign o_sclk     = div_clk_q;
    assign o_cs_n     = cs_n_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        o_div_start_n = 1'b1;
        o_rx_valid    = 1'b0;
        o_err         = 1'b0;
        case (state_reg)
            ST_IDLE:  if (handshake) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_START;
            ST_START: begin
                o_div_start_n = 1'b0;
                state_next    = ST_ARM;
            end
            ST_ARM:   if (!i_div_ready) state_next = ST_SHIFT;
            ST_SHIFT: if (i_div_ready) state_next = ST_DONE;
            ST_DONE: begin
                o_rx_valid = 1'b1;
                o_err      = (rise_cnt_reg != WIDTH_CNT);
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Rise is registered so bits move one cycle after the pad SCLK edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_clk_q    <= 1'b0;
            rise_reg     <= 1'b0;
            ready_reg    <= 1'b0;
            cs_n_reg     <= 1'b1;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rise_cnt_reg <= '0;
        end else begin
            div_clk_q <= i_div_clk;
            rise_reg  <= i_div_clk & ~div_clk_q;
            ready_reg <= (state_next == ST_IDLE);
            if (handshake) begin
                tx_shift_reg <= i_tx_data;
                rx_shift_reg <= '0;
                rise_cnt_reg <= '0;
                cs_n_reg     <= 1'b0;
            end else if (rise_evt) begin
                tx_shift_reg <= tx_shifted;
                rx_shift_reg <= rx_shifted;
                rise_cnt_reg <= rise_cnt_reg + 4'd1;
            end
            if (frame_end) begin
                rx_data_reg <= rx_capture;
            end
            if (state_reg == ST_DONE) begin
                cs_n_reg     <= 1'b1;
                rise_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine with a behavioural clock_divider model.
module tb_spi_byte_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, err;
    logic       div_clk = 1'b0;
    logic       div_ready = 1'b1;
    logic       div_start_n, sclk, mosi, cs_n, miso;
    logic       miso_tie = 1'b0;

    int div_p = 2;
    int div_limit = 8;
    int dcnt = 0;
    int drises = 0;

    int passed = 0;
    int total = 0;

    int         rx_count = 0;
    int         sclk_rises = 0;
    int         mosi_hi_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic       last_err = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       mosi_q[$];

    always #5 clk = ~clk;

    assign miso = miso_tie | mosi;

    spi_byte_engine #(.WIDTH(8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_err         (err),
        .i_div_clk     (div_clk),
        .i_div_ready   (div_ready),
        .o_div_start_n (div_start_n),
        .o_sclk        (sclk),
        .o_mosi        (mosi),
        .i_miso        (miso),
        .o_cs_n        (cs_n)
    );

    // Divider model: div_limit SCLK periods of div_p cycles (high half first), then ready
    always @(posedge clk) begin
        if (div_ready) begin
            if (!div_start_n) begin
                div_ready <= 1'b0;
                div_clk   <= 1'b1;
                dcnt      <= 0;
                drises    <= 1;
            end
        end else if (dcnt == div_p - 1) begin
            if (drises >= div_limit) begin
                div_ready <= 1'b1;
                div_clk   <= 1'b0;
            end else begin
                dcnt    <= 0;
                div_clk <= 1'b1;
                drises  <= drises + 1;
            end
        end else begin
            dcnt    <= dcnt + 1;
            div_clk <= ((dcnt + 1) < (div_p / 2));
        end
    end

    always @(negedge clk) begin
        sclk_prev <= sclk;
        if (rx_valid) begin
            rx_count <= rx_count + 1;
            last_rx  <= rx_data;
            last_err <= err;
        end
        if (sclk && !sclk_prev && !cs_n) begin
            sclk_rises <= sclk_rises + 1;
            mosi_q.push_back(mosi);
        end
        if (!cs_n && mosi) mosi_hi_cnt <= mosi_hi_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_byte(input logic [7:0] d);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (tx_ready !== 1'b1) $display("FAIL start_ready: tx_ready=%b required 1", tx_ready);
        else passed++;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int snap);
        int n;
        n = 0;
        while (rx_count == snap && n < 400) begin
            tick();
            n++;
        end
        total++;
        if (rx_count == snap) $display("FAIL rx_timeout: no rx_valid after %0d cycles, required one", n);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (16) tick();
        total++;
        if ({tx_ready, cs_n, div_start_n, sclk, mosi, rx_valid, err} !== 7'b0110000)
            $display("FAIL reset_hold: outs=%b required 0110000",
                     {tx_ready, cs_n, div_start_n, sclk, mosi, rx_valid, err});
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if ({tx_ready, cs_n, div_start_n, sclk, mosi, rx_valid, err} !== 7'b1110000)
            $display("FAIL reset_release: outs=%b required 1110000",
                     {tx_ready, cs_n, div_start_n, sclk, mosi, rx_valid, err});
        else passed++;
        total++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", rx_data);
        else passed++;
        $display("reset: outputs=%b rx_data=%h", {tx_ready, cs_n, div_start_n, sclk, mosi, rx_valid, err}, rx_data);
    endtask

    task automatic test_loopback();
        int         snap, qs;
        logic [7:0] got;
        div_p    = 2;
        miso_tie = 1'b0;
        snap     = rx_count;
        qs       = mosi_q.size();
        start_byte(8'hA5);
        total++;
        if ({cs_n, div_start_n} !== 2'b01) $display("FAIL setup_cycle: cs_n,start_n=%b required 01", {cs_n, div_start_n});
        else passed++;
        tick();
        total++;
        if ({cs_n, div_start_n} !== 2'b00) $display("FAIL start_strobe: cs_n,start_n=%b required 00", {cs_n, div_start_n});
        else passed++;
        tick();
        total++;
        if (div_start_n !== 1'b1) $display("FAIL strobe_width: start_n=%b required 1", div_start_n);
        else passed++;
        wait_rx(snap);
        total++;
        if (last_rx !== 8'hA5 || last_err !== 1'b0)
            $display("FAIL loop_rx: rx=%h err=%b required a5 0", last_rx, last_err);
        else passed++;
        got = 8'h00;
        for (int i = 0; i < 8; i++) if (qs + i < mosi_q.size()) got[7-i] = mosi_q[qs+i];
        total++;
        if (got !== 8'b10100101 || mosi_q.size() - qs != 8)
            $display("FAIL mosi_seq: bits=%b count=%0d required 10100101 count 8", got, mosi_q.size() - qs);
        else passed++;
        tick();
        total++;
        if (tx_ready !== 1'b1) $display("FAIL ready_return: tx_ready=%b required 1", tx_ready);
        else passed++;
        repeat (4) tick();
        total++;
        if (rx_count != snap + 1) $display("FAIL single_valid: pulses=%0d required 1", rx_count - snap);
        else passed++;
        $display("loopback: tx=a5 rx=%h mosi=%b err=%b", last_rx, got, last_err);
    endtask

    task automatic test_back_to_back();
        int snap, n, hi;
        div_p = 4;
        snap  = rx_count;
        n     = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hC3;
        wait_rx(snap);
        total++;
        if (last_rx !== 8'h3C) $display("FAIL b2b_first: rx=%h required 3c", last_rx);
        else passed++;
        n  = 0;
        hi = 0;
        do begin
            tick();
            n++;
            if (cs_n) hi++;
        end while (cs_n !== 1'b0 && n < 20);
        tx_valid = 1'b0;
        total++;
        if (hi != 1) $display("FAIL b2b_gap: cs_n high %0d cycles, required 1", hi);
        else passed++;
        wait_rx(snap + 1);
        total++;
        if (last_rx !== 8'hC3 || rx_count != snap + 2)
            $display("FAIL b2b_second: rx=%h frames=%0d required c3 2", last_rx, rx_count - snap);
        else passed++;
        $display("back_to_back: rx=3c,%h cs_gap=%0d", last_rx, hi);
    endtask

    task automatic test_miso_high();
        int snap, mh;
        div_p    = 2;
        miso_tie = 1'b1;
        snap     = rx_count;
        mh       = mosi_hi_cnt;
        start_byte(8'h00);
        wait_rx(snap);
        miso_tie = 1'b0;
        total++;
        if (last_rx !== 8'hFF) $display("FAIL miso_high_rx: rx=%h required ff", last_rx);
        else passed++;
        total++;
        if (mosi_hi_cnt != mh) $display("FAIL mosi_const0: mosi high %0d cycles, required 0", mosi_hi_cnt - mh);
        else passed++;
        $display("miso_high: tx=00 rx=%h", last_rx);
    endtask

    task automatic test_midframe_reset();
        int snap, sr, n;
        div_p    = 4;
        miso_tie = 1'b0;
        snap     = rx_count;
        sr       = sclk_rises;
        start_byte(8'hF0);
        n = 0;
        while (sclk_rises < sr + 3 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (sclk_rises != sr + 3) $display("FAIL third_rise: rises=%0d required 3", sclk_rises - sr);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({tx_ready, cs_n, div_start_n, sclk, mosi, rx_valid, err} !== 7'b0110000 || rx_data !== 8'h00)
            $display("FAIL midframe_reset: outs=%b rx=%h required 0110000 00",
                     {tx_ready, cs_n, div_start_n, sclk, mosi, rx_valid, err}, rx_data);
        else passed++;
        repeat (3) tick();
        rst = 1'b0;
        n   = 0;
        while (div_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (rx_count != snap) $display("FAIL abandon_no_valid: pulses=%0d required 0", rx_count - snap);
        else passed++;
        start_byte(8'h5A);
        wait_rx(snap);
        total++;
        if (last_rx !== 8'h5A || last_err !== 1'b0)
            $display("FAIL after_reset_rx: rx=%h err=%b required 5a 0", last_rx, last_err);
        else passed++;
        $display("midframe_reset: next rx=%h", last_rx);
    endtask

    task automatic test_short_frame();
        int snap;
        div_p     = 2;
        div_limit = 6;
        snap      = rx_count;
        start_byte(8'h96);
        wait_rx(snap);
        total++;
        if (last_err !== 1'b1) $display("FAIL short_err: err=%b required 1", last_err);
        else passed++;
        tick();
        total++;
        if ({tx_ready, cs_n} !== 2'b11 || rx_count != snap + 1)
            $display("FAIL short_idle: ready,cs_n=%b frames=%0d required 11 1", {tx_ready, cs_n}, rx_count - snap);
        else passed++;
        div_limit = 8;
        $display("short_frame: err=%b ready=%b", last_err, tx_ready);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_miso_high();
        test_midframe_reset();
        test_short_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
